// File: rtl/counter_sched.sv
// Round-robin scheduler that shares one counter4b between requesters A and B.
// A job loads the counter, runs until N RCO events (or abort), then reports Q.
module counter_sched #(
    parameter int WIDTH = 4,
    parameter int NW    = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ_A,
    input  logic             REQ_B,
    input  logic [1:0]       MODO_A,
    input  logic [1:0]       MODO_B,
    input  logic [WIDTH-1:0] D_A,
    input  logic [WIDTH-1:0] D_B,
    input  logic [NW-1:0]    N_A,
    input  logic [NW-1:0]    N_B,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             DONE_A,
    output logic             DONE_B,
    output logic             ABORTED,
    output logic [WIDTH-1:0] RESULT,
    output logic             C_ENABLE,
    output logic [1:0]       C_MODO,
    output logic [WIDTH-1:0] C_D,
    input  logic [WIDTH-1:0] C_Q,
    input  logic             C_RCO,
    input  logic             C_LOAD
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODO_LD = 2'b11;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;     // 0 = A, 1 = B
    logic             ptr_q, ptr_d;         // round-robin winner on a tie
    logic             abort_q, abort_d;
    logic             first_q, first_d;     // first RUN cycle, where LOAD must be seen
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [NW-1:0]    n_q, n_d;
    logic [NW-1:0]    evt_q, evt_d;
    logic [NW-1:0]    evt_inc;
    logic             owner_req;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b0;
            abort_q  <= 1'b0;
            first_q  <= 1'b0;
            evt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            abort_q  <= abort_d;
            first_q  <= first_d;
            evt_q    <= evt_d;
            result_q <= result_d;
        end
        mode_q <= mode_d;
        d_q    <= d_d;
        n_q    <= n_d;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        abort_d   = abort_q;
        first_d   = first_q;
        evt_d     = evt_q;
        result_d  = result_q;
        mode_d    = mode_q;
        d_d       = d_q;
        n_d       = n_q;
        evt_inc   = evt_q + 1'b1;
        owner_req = owner_q ? REQ_B : REQ_A;

        case (state_q)
            S_IDLE: begin
                if (REQ_A || REQ_B) begin
                    owner_d = (REQ_A && REQ_B) ? ptr_q : REQ_B;
                    mode_d  = owner_d ? MODO_B : MODO_A;
                    d_d     = owner_d ? D_B : D_A;
                    n_d     = owner_d ? N_B : N_A;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                evt_d   = '0;
                abort_d = 1'b0;
                first_d = 1'b1;
                state_d = (mode_q == MODO_LD || n_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                first_d = 1'b0;
                if (C_RCO) begin
                    evt_d = evt_inc;
                end
                // Abort wins over a simultaneous final RCO
                if (!owner_req || (first_q && !C_LOAD)) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else if (C_RCO && evt_inc == n_q) begin
                    abort_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_d = C_Q;
                ptr_d    = ~owner_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter is disabled in DONE, so Q is stable and already post-wrap there
    always_comb begin
        GNT_A    = 1'b0;
        GNT_B    = 1'b0;
        DONE_A   = 1'b0;
        DONE_B   = 1'b0;
        ABORTED  = 1'b0;
        RESULT   = result_q;
        C_ENABLE = 1'b0;
        C_MODO   = 2'b00;
        C_D      = '0;

        if (state_q != S_IDLE) begin
            GNT_A = ~owner_q;
            GNT_B = owner_q;
        end

        case (state_q)
            S_LOAD: begin
                C_ENABLE = 1'b1;
                C_MODO   = MODO_LD;
                C_D      = d_q;
            end
            S_RUN: begin
                C_ENABLE = 1'b1;
                C_MODO   = mode_q;
                C_D      = d_q;
            end
            S_DONE: begin
                DONE_A  = ~owner_q;
                DONE_B  = owner_q;
                ABORTED = abort_q;
                RESULT  = C_Q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural counter4b attached to
// its counter port set.
module tb_counter_sched;

    localparam int WIDTH = 4;
    localparam int NW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_a, req_b;
    logic [1:0]       modo_a, modo_b;
    logic [WIDTH-1:0] d_a, d_b;
    logic [NW-1:0]    n_a, n_b;
    logic             gnt_a, gnt_b, done_a, done_b, aborted;
    logic [WIDTH-1:0] result;
    logic             c_enable;
    logic [1:0]       c_modo;
    logic [WIDTH-1:0] c_d;
    logic [WIDTH-1:0] c_q;
    logic             c_rco;
    logic             c_load;

    logic             cld;
    logic             block_ld;
    logic             rco_clr;
    int               rco_seen;
    int               n_tests = 0;
    int               n_fail  = 0;

    always #5 clk = ~clk;

    counter_sched #(.WIDTH(WIDTH), .NW(NW)) dut (
        .CLK(clk), .RESET(rst),
        .REQ_A(req_a), .REQ_B(req_b),
        .MODO_A(modo_a), .MODO_B(modo_b),
        .D_A(d_a), .D_B(d_b),
        .N_A(n_a), .N_B(n_b),
        .GNT_A(gnt_a), .GNT_B(gnt_b),
        .DONE_A(done_a), .DONE_B(done_b),
        .ABORTED(aborted), .RESULT(result),
        .C_ENABLE(c_enable), .C_MODO(c_modo), .C_D(c_d),
        .C_Q(c_q), .C_RCO(c_rco), .C_LOAD(c_load)
    );

    // counter4b: 00 up, 01 down, 10 up by 3, 11 load; RCO flags the wrap
    always @(posedge clk) begin
        if (rst) begin
            c_q <= '0;
            cld <= 1'b0;
        end else if (c_enable) begin
            case (c_modo)
                2'b00: c_q <= c_q + 4'd1;
                2'b01: c_q <= c_q - 4'd1;
                2'b10: c_q <= c_q + 4'd3;
                default: c_q <= c_d;
            endcase
            cld <= (c_modo == 2'b11);
        end else begin
            cld <= 1'b0;
        end
    end

    assign c_rco  = c_enable && ((c_modo == 2'b00 && c_q == 4'hF) ||
                                 (c_modo == 2'b01 && c_q == 4'h0) ||
                                 (c_modo == 2'b10 && c_q >= 4'hD));
    assign c_load = cld & ~block_ld;

    always @(posedge clk) begin
        if (rco_clr) rco_seen <= 0;
        else if (c_rco) rco_seen <= rco_seen + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        logic seen;

        rst = 1'b1; req_a = 0; req_b = 0;
        modo_a = 0; modo_b = 0; d_a = 0; d_b = 0; n_a = 0; n_b = 0;
        block_ld = 0; rco_clr = 1;
        step(); step();
        rst = 1'b0; rco_clr = 0;
        chk("reset_grants", {gnt_a, gnt_b, done_a, done_b, aborted}, 5'b0);
        chk("reset_result", result, 4'h0);
        chk("reset_counter_if", {c_enable, c_modo, c_d}, 7'b0);

        // Single job A: load C, count up to the wrap, one RCO
        d_a = 4'hC; modo_a = 2'b00; n_a = 4'd1; req_a = 1;
        step();
        chk("t1_load_gnt", {gnt_a, gnt_b}, 2'b10);
        chk("t1_load_modo", c_modo, 2'b11);
        chk("t1_load_d", c_d, 4'hC);
        chk("t1_load_en", c_enable, 1'b1);
        step();
        chk("t1_run_modo", c_modo, 2'b00);
        chk("t1_run_q", c_q, 4'hC);
        chk("t1_run_loadflag", c_load, 1'b1);
        step(); step(); step();
        chk("t1_rco_at_f", {c_q, c_rco}, {4'hF, 1'b1});
        chk("t1_no_done_yet", done_a, 1'b0);
        step();
        chk("t1_done", {done_a, done_b, aborted}, 3'b100);
        chk("t1_result", result, 4'h0);
        chk("t1_done_outs", {gnt_a, c_enable}, 2'b10);
        req_a = 0;
        step();
        chk("t1_idle", {gnt_a, done_a}, 2'b00);

        // Simultaneous requests after reset: A first, B next, then A again
        rst = 1; step(); rst = 0;
        modo_a = 2'b11; d_a = 4'h7; n_a = 4'd2;
        modo_b = 2'b11; d_b = 4'h9; n_b = 4'd2;
        req_a = 1; req_b = 1;
        step();
        chk("t2_first_gnt", {gnt_a, gnt_b}, 2'b10);
        step();
        chk("t2_done_a", {done_a, done_b}, 2'b10);
        chk("t2_result_a", result, 4'h7);
        step();
        chk("t2_idle_gap", {gnt_a, gnt_b}, 2'b00);
        step();
        chk("t2_b_gnt", {gnt_a, gnt_b}, 2'b01);
        chk("t2_b_d", c_d, 4'h9);
        step();
        chk("t2_done_b", {done_a, done_b, aborted}, 3'b010);
        chk("t2_result_b", result, 4'h9);
        req_b = 0;
        step();
        chk("t2_result_held", result, 4'h9);
        step();
        chk("t2_a_again", {gnt_a, gnt_b}, 2'b10);
        step();
        chk("t2_done_a2", {done_a, result}, {1'b1, 4'h7});
        req_a = 0;
        step();

        // Load-only via mode 11, then via N = 0
        modo_b = 2'b11; d_b = 4'h5; n_b = 4'd3; req_b = 1;
        step(); step();
        chk("t3_ldonly_done", {done_b, aborted, result}, {1'b1, 1'b0, 4'h5});
        req_b = 0;
        step();
        modo_b = 2'b00; d_b = 4'h5; n_b = 4'd0; req_b = 1;
        step(); step();
        chk("t3_n0_done", {done_b, aborted, result}, {1'b1, 1'b0, 4'h5});
        req_b = 0;
        step();

        // Abort: A drops REQ after 3 RUN cycles, pointer must move to B
        modo_a = 2'b00; d_a = 4'h0; n_a = 4'd3; req_a = 1;
        step(); step(); step(); step();
        chk("t4_run3_q", c_q, 4'h2);
        req_a = 0;
        step();
        chk("t4_abort_done", {done_a, aborted}, 2'b11);
        chk("t4_abort_result", result, 4'h3);
        step();
        modo_a = 2'b11; modo_b = 2'b11; d_a = 4'h7; d_b = 4'h9;
        req_a = 1; req_b = 1;
        step();
        chk("t4_ptr_b", {gnt_a, gnt_b}, 2'b01);
        step();
        chk("t4_done_b", done_b, 1'b1);
        req_a = 0; req_b = 0;
        step();

        // Multi-wrap: 15 RCO events from D = 0 counting up
        rco_clr = 1; step(); rco_clr = 0;
        modo_a = 2'b00; d_a = 4'h0; n_a = 4'hF; req_a = 1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 400) begin
            step();
            cyc++;
            seen = done_a;
        end
        chk("t5_done_seen", seen, 1'b1);
        chk("t5_latency", cyc, 242);
        chk("t5_rco_count", rco_seen, 15);
        chk("t5_result", {aborted, result}, {1'b0, 4'h0});
        req_a = 0;
        step();

        // Counter never acknowledges the load: job aborts
        block_ld = 1;
        modo_a = 2'b00; d_a = 4'h0; n_a = 4'd2; req_a = 1;
        step(); step(); step();
        chk("t6_ldchk_abort", {done_a, aborted, result}, {1'b1, 1'b1, 4'h1});
        req_a = 0; block_ld = 0;
        step();

        // Reset mid-RUN for two cycles
        modo_a = 2'b00; d_a = 4'h0; n_a = 4'd5; req_a = 1;
        step(); step(); step();
        chk("t7_running", {gnt_a, c_enable}, 2'b11);
        rst = 1; req_a = 0;
        step();
        chk("t7_rst_outs", {gnt_a, gnt_b, done_a, done_b, aborted, c_enable, c_modo, c_d}, 12'b0);
        chk("t7_rst_result", result, 4'h0);
        step();
        rst = 0;
        step();
        chk("t7_after_rst", {gnt_a, done_a, c_enable}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sched.md
# counter_sched

Scheduler that shares one `counter4b` instance between two requesters, A and B. Each requester submits a job: an initial value, a count mode and the number of RCO (wrap) events to run. The block arbitrates round-robin, loads the counter, runs it until the requested number of RCO pulses has been seen, then returns the final Q and releases the counter. It sits between requester logic and the `counter4b` port set (CLK, ENABLE, RESET, D, MODO, Q, RCO, LOAD).

## Interface
- `WIDTH`, 4, counter data width (D/Q).
- `NW`, 4, width of the RCO-event job length.
- `CLK` in 1: single clock; all state changes on the rising edge.
- `RESET` in 1: synchronous, active-high.
- `REQ_A`, `REQ_B` in 1: job request; must be held high until that requester's `DONE_x` pulse.
- `MODO_A`, `MODO_B` in 2: job count mode; `2'b11` means a load-only job.
- `D_A`, `D_B` in WIDTH: job initial value.
- `N_A`, `N_B` in NW: number of RCO events to run.
- `GNT_A`, `GNT_B` out 1: requester currently owns the counter.
- `DONE_A`, `DONE_B` out 1: one-cycle job completion pulse.
- `ABORTED` out 1: qualifies `DONE_x`; high means the job ended early.
- `RESULT` out WIDTH: counter Q captured at job end; valid with `DONE_x`, held until the next DONE.
- `C_ENABLE` out 1: drives counter ENABLE.
- `C_MODO` out 2: drives counter MODO.
- `C_D` out WIDTH: drives counter D.
- `C_Q` in WIDTH: counter Q.
- `C_RCO` in 1: counter RCO.
- `C_LOAD` in 1: counter LOAD; monitored only, used for the load check.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Moore outputs are decoded from registered state plus the latched owner.
- **IDLE**
  - `C_ENABLE`=0, `C_MODO`=00, `C_D`=0.
  - If any REQ is high, pick the owner and latch its MODO, D and N. Next state is LOAD.
  - If both REQs are high, the requester named by the priority pointer wins.
- **LOAD**
  - Drive `C_ENABLE`=1, `C_MODO`=2'b11, `C_D`=latched D, for exactly one cycle.
  - If latched mode is 11 or latched N=0, next state is DONE. Otherwise next state is RUN.
- **RUN**
  - Drive `C_ENABLE`=1, `C_MODO`=latched mode, `C_D`=latched D.
  - On each edge where `C_RCO`=1, the event counter increments.
  - When the event counter reaches N (the edge seeing the N-th RCO), next state is DONE with `ABORTED`=0.
  - If the owner's REQ is low at an edge, next state is DONE with `ABORTED`=1. Abort takes precedence over a simultaneous N-th RCO.
- **DONE**
  - Drive `C_ENABLE`=0.
  - Pulse the owner's `DONE_x` for one cycle and register `RESULT`=`C_Q` on entry.
  - The priority pointer moves to the other requester. Next state is IDLE.
- `GNT_x`=1 while state is LOAD, RUN or DONE and x is the owner. `GNT_A` and `GNT_B` are never both 1.
- Event counter: NW bits, cleared in LOAD, cannot wrap (exit occurs at N ≤ 2^NW−1).
- Load check: if `C_LOAD`=0 in the cycle after LOAD, the job ends via DONE with `ABORTED`=1.
- Requester inputs are ignored outside IDLE, except the owner's REQ used for the abort check.

## Timing
- **Reset values:** state IDLE; all outputs 0 (`GNT_x`, `DONE_x`, `ABORTED`, `RESULT`, `C_*`); priority pointer = A; event counter 0.
- **Reset mid-job:** next edge goes to IDLE, no DONE pulse, `C_ENABLE`=0 the following cycle.
- **Request to load:** REQ sampled at edge t → LOAD during cycle t+1. The counter loads at the end of t+1; RUN starts at t+2.
- **Load-only job (mode 11 or N=0):** DONE in cycle t+2, `RESULT`=D.
- **RUN job:** DONE in the cycle after the edge sampling the N-th RCO. `RESULT` = Q at that DONE-entry edge, i.e. the post-wrap value.
- **Back-to-back:** minimum 1 IDLE cycle between jobs, so a job turnaround is ≥ 3 cycles + run length.
- **REQ still high after DONE:** the same requester may be re-granted only if the other REQ is low (round-robin).
- `RCO` during LOAD or DONE is not counted.

## Test plan
- **Reset:** RESET=1 for 2 cycles mid-RUN → next cycle all outputs 0, state IDLE, no `DONE_x`.
- **Single job A:** REQ_A, D_A=4'hC, MODO_A=00 (up), N_A=1.
  - Required: `GNT_A` at t+1; `C_MODO`=11 and `C_D`=C at t+1.
  - Then up-count C,D,E,F,0; `RCO` once.
  - `DONE_A` with `ABORTED`=0 and the RESULT of the wrap.
  - Total latency = 2 + 4 run cycles + 1.
- **Simultaneous requests:** REQ_A and REQ_B both high after reset → A served first, B granted after 1 IDLE cycle. A re-requests immediately → B still precedes A's second job.
- **Load-only and N=0:** MODO_B=11, D_B=4'h5 → `DONE_B` at t+2, `RESULT`=5. Same outcome for MODO_B=00, N_B=0.
- **Abort:** REQ_A dropped after 3 RUN cycles with N_A=3 → DONE next cycle, `ABORTED`=1, `RESULT`=current Q; pointer moves to B.
- **Multi-wrap:** N_A=4'hF, MODO_A=00, D_A=0 → exactly 15 `RCO` pulses counted before `DONE_A`; the event counter never wraps.
